// File: rtl/tt_um_sai222777.sv
// Bit-serial LFSR stream cipher tile.
// A 32-bit Galois LFSR produces a keystream that is XORed onto the plaintext
// (TX) and ciphertext (RX) bit streams. Seed, taps and mode bits are loaded
// through a 66-bit serial configuration chain.
module tt_um_sai222777 #(
   parameter int M = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out
);

   localparam int CW = 2*M + 2;
   localparam logic [M-1:0] SEED_DEF = M'(32'hACE1ACE1);
   localparam logic [M-1:0] TAPS_DEF = M'(32'h80200003);

   // Input bit map
   logic [1:0] w_sel;
   logic       w_tx_p;
   logic       w_rx_e;
   logic       w_cfg_en;
   logic       w_cfg_i;
   logic       w_tx_en;
   logic       w_rx_en;

   assign w_sel    = ui_in[1:0];
   assign w_tx_p   = ui_in[2];
   assign w_rx_e   = ui_in[3];
   assign w_cfg_en = ui_in[4];
   assign w_cfg_i  = ui_in[5];
   assign w_tx_en  = ui_in[6];
   assign w_rx_en  = ui_in[7];

   logic [CW-1:0] r_cfg;
   logic          r_cfg_en_d;
   logic [M-1:0]  r_lfsr;
   logic          r_tx_e;
   logic          r_rx_p;
   logic          r_dbg_tx_p;
   logic          r_dbg_rx_e;
   logic [7:0]    r_cnt;

   // One Galois right-shift step
   function automatic logic [M-1:0] f_step(input logic [M-1:0] s, input logic [M-1:0] t);
      f_step = (s >> 1) ^ (s[0] ? t : '0);
   endfunction

   // Keystream bit selection from the current LFSR state
   function automatic logic f_key(input logic [M-1:0] s, input logic [1:0] sel, input logic inv);
      logic a, b, c, k;
      a = s[0];
      b = s[M/2];
      c = s[M-1];
      case (sel)
         2'd0:    k = a;
         2'd1:    k = a ^ b;
         2'd2:    k = a ^ c;
         default: k = (a & b) | (a & c) | (b & c);
      endcase
      f_key = k ^ inv;
   endfunction

   // Zero fields fall back to the built-in defaults
   logic [M-1:0] w_seed_eff;
   logic [M-1:0] w_taps_eff;
   logic         w_invert;
   logic         w_dual;
   logic         w_k;
   logic         w_load;
   logic         w_active;
   logic [M-1:0] w_step1;
   logic [M-1:0] w_step2;

   assign w_seed_eff = (r_cfg[M-1:0] == '0)   ? SEED_DEF : r_cfg[M-1:0];
   assign w_taps_eff = (r_cfg[2*M-1:M] == '0) ? TAPS_DEF : r_cfg[2*M-1:M];
   assign w_invert   = r_cfg[2*M];
   assign w_dual     = r_cfg[2*M+1];
   assign w_k        = f_key(r_lfsr, w_sel, w_invert);
   assign w_step1    = f_step(r_lfsr, w_taps_eff);
   assign w_step2    = f_step(w_step1, w_taps_eff);

   // The load edge is the first cfg_en=0 edge after a shift; it does no crypto work
   assign w_load     = !w_cfg_en && r_cfg_en_d;
   assign w_active   = !w_cfg_en && !r_cfg_en_d && (w_tx_en || w_rx_en);

   // Configuration chain shifts MSB-ward; the oldest bit leaves through cfg_o
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg      <= '0;
         r_cfg_en_d <= 1'b0;
      end else begin
         r_cfg_en_d <= w_cfg_en;
         if (w_cfg_en)
            r_cfg <= {r_cfg[CW-2:0], w_cfg_i};
      end
   end

   // LFSR: seed load after configuration, step on enabled cycles, hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_lfsr <= SEED_DEF;
      else if (w_load)
         r_lfsr <= w_seed_eff;
      else if (w_active)
         r_lfsr <= w_dual ? w_step2 : w_step1;
   end

   // Cipher outputs update only on their own enable and hold between
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_e <= 1'b0;
         r_rx_p <= 1'b0;
      end else if (w_active) begin
         if (w_tx_en) r_tx_e <= w_tx_p ^ w_k;
         if (w_rx_en) r_rx_p <= w_rx_e ^ w_k;
      end
   end

   // Debug echo of the raw serial inputs and free-running heartbeat counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dbg_tx_p <= 1'b0;
         r_dbg_rx_e <= 1'b0;
         r_cnt      <= 8'd0;
      end else begin
         r_dbg_tx_p <= w_tx_p;
         r_dbg_rx_e <= w_rx_e;
         r_cnt      <= r_cnt + 8'd1;
      end
   end

   assign uo_out = {r_cnt[7:5], r_cfg[CW-1], r_dbg_rx_e, r_dbg_tx_p, r_rx_p, r_tx_e};

endmodule

// File: tb/tb_tt_um_sai222777.sv
// Testbench for the LFSR stream cipher tile: table-driven round trips plus
// directed sequences, with a cycle model feeding an expected-output queue.
module tb_tt_um_sai222777;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo_out;

   int n_checks = 0;
   int n_err    = 0;

   tt_um_sai222777 dut (
      .clk    (clk),
      .rst    (rst),
      .ui_in  (ui_in),
      .uo_out (uo_out)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [65:0] m_cfg;
   logic [31:0] m_lfsr;
   logic        m_pend;
   logic        m_tx, m_rx, m_dtx, m_drx;
   logic [7:0]  m_cnt;
   logic [7:0]  exp_q[$];

   typedef struct {
      logic [31:0] seed;
      logic [31:0] taps;
      logic        inv;
      logic        dual;
      logic [1:0]  sel;
      logic [15:0] pt;
      logic [15:0] exp_dec;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic m_key(input logic [31:0] s, input logic [1:0] sel, input logic inv);
      logic a, b, c, k;
      a = s[0]; b = s[16]; c = s[31];
      case (sel)
         2'd0: k = a;
         2'd1: k = a ^ b;
         2'd2: k = a ^ c;
         default: k = (a + b + c) >= 2;
      endcase
      return k ^ inv;
   endfunction

   function automatic logic [31:0] m_adv(input logic [31:0] s, input logic [31:0] t, input int n);
      logic [31:0] r;
      r = s;
      for (int i = 0; i < n; i++) begin
         if (r[0]) r = {1'b0, r[31:1]} ^ t;
         else      r = {1'b0, r[31:1]};
      end
      return r;
   endfunction

   task automatic model_reset();
      m_cfg = '0; m_lfsr = 32'hACE1ACE1; m_pend = 0;
      m_tx = 0; m_rx = 0; m_dtx = 0; m_drx = 0; m_cnt = 0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      ui_in = 8'h00;
      rst = 1'b1;
      tick();
      tick();
      check("reset_uo", {24'h0, uo_out}, 32'h0);
      model_reset();
      rst = 1'b0;
   endtask

   // Drive one clock: model predicts, queue holds the expectation, compare after the edge
   task automatic drive(input logic cen, input logic ci, input logic ten, input logic ren,
                        input logic tp, input logic re, input logic [1:0] s);
      logic [31:0] taps, seed;
      logic        k;
      logic [7:0]  e;
      ui_in = {ren, ten, ci, cen, re, tp, s};
      taps = (m_cfg[63:32] == 0) ? 32'h80200003 : m_cfg[63:32];
      seed = (m_cfg[31:0]  == 0) ? 32'hACE1ACE1 : m_cfg[31:0];
      if (cen) begin
         m_cfg  = {m_cfg[64:0], ci};
         m_pend = 1;
      end else if (m_pend) begin
         m_lfsr = seed;
         m_pend = 0;
      end else if (ten || ren) begin
         k = m_key(m_lfsr, s, m_cfg[64]);
         if (ten) m_tx = tp ^ k;
         if (ren) m_rx = re ^ k;
         m_lfsr = m_adv(m_lfsr, taps, m_cfg[65] ? 2 : 1);
      end
      m_dtx = tp; m_drx = re; m_cnt = m_cnt + 1;
      exp_q.push_back({m_cnt[7:5], m_cfg[65], m_drx, m_dtx, m_rx, m_tx});
      tick();
      e = exp_q.pop_front();
      check("uo_cycle", {24'h0, uo_out}, {24'h0, e});
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 2'd0);
   endtask

   task automatic cfg_load(input logic [65:0] v);
      for (int i = 65; i >= 0; i--) drive(1, v[i], 0, 0, 0, 0, 2'd0);
      idle();
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [15:0] ct, dec;
      do_reset();
      cfg_load({v.dual, v.inv, v.taps, v.seed});
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 1, 0, v.pt[i], 0, v.sel);
         ct[i] = uo_out[0];
         idle();
      end
      do_reset();
      cfg_load({v.dual, v.inv, v.taps, v.seed});
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 1, 0, ct[i], v.sel);
         dec[i] = uo_out[1];
         idle();
      end
      check($sformatf("roundtrip_%0d", idx), {16'h0, dec}, {16'h0, v.exp_dec});
      if (idx == 0) begin
         n_checks++;
         if (ct == v.pt) begin
            n_err++;
            $display("FAIL ct_ne_pt actual=%0h expected_not=%0h", ct, v.pt);
         end
      end
   endtask

   initial begin
      logic [65:0] pat;
      vecs[0] = '{32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 16'hF0F0, 16'hF0F0};
      vecs[1] = '{32'h12345678, 32'h80000057, 1'b0, 1'b0, 2'd0, 16'h1234, 16'h1234};
      vecs[2] = '{32'h12345678, 32'h80000057, 1'b0, 1'b0, 2'd1, 16'h1234, 16'h1234};
      vecs[3] = '{32'h12345678, 32'h80000057, 1'b0, 1'b0, 2'd2, 16'h1234, 16'h1234};
      vecs[4] = '{32'h12345678, 32'h80000057, 1'b0, 1'b0, 2'd3, 16'h1234, 16'h1234};
      vecs[5] = '{32'hDEADBEEF, 32'hA3000000, 1'b1, 1'b0, 2'd1, 16'h1234, 16'h1234};
      vecs[6] = '{32'h0BADF00D, 32'h80200003, 1'b0, 1'b1, 2'd2, 16'h1234, 16'h1234};
      vecs[7] = '{32'h00000001, 32'hB4BCD35C, 1'b1, 1'b1, 2'd3, 16'h1234, 16'h1234};
      vecs[8] = '{32'hCAFE0001, 32'h0, 1'b0, 1'b0, 2'd0, 16'h1234, 16'h1234};

      // First keystream bit after reset, both plaintext values
      do_reset();
      drive(0, 0, 1, 0, 0, 0, 2'd0);
      check("first_bit_tp0", {31'h0, uo_out[0]}, 32'h1);
      do_reset();
      drive(0, 0, 1, 0, 1, 0, 2'd0);
      check("first_bit_tp1", {31'h0, uo_out[0]}, 32'h0);

      // Round trips from the vector table
      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Config chain pass-through, MSB first
      do_reset();
      pat = 66'h2_A5C3_0F1E_9B7D_4826;
      for (int i = 65; i >= 0; i--) drive(1, pat[i], 0, 0, 0, 0, 2'd0);
      for (int j = 0; j < 66; j++) begin
         check("cfg_o_chain", {31'h0, uo_out[4]}, {31'h0, pat[65-j]});
         drive(1, 0, 0, 0, 0, 0, 2'd0);
      end

      // Simultaneous tx/rx with equal inputs, then a cfg_en freeze mid-stream
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 1, 1, i[0], i[0], 2'd1);
         check("tx_eq_rx", {31'h0, uo_out[0]}, {31'h0, uo_out[1]});
      end
      for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 1, 0, 2'd1);
      idle();
      for (int i = 0; i < 6; i++) drive(0, 0, 1, 1, i[1], i[1], 2'd2);

      // Asynchronous reset while partially configured
      do_reset();
      for (int i = 0; i < 30; i++) drive(1, 1, 0, 0, 1, 1, 2'd0);
      #2 rst = 1'b1;
      #1 check("async_reset_uo", {24'h0, uo_out}, 32'h0);
      model_reset();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0, 0, 2'd3);

      // Heartbeat advances once every 32 clocks
      do_reset();
      for (int i = 0; i < 31; i++) idle();
      check("hb_31", {29'h0, uo_out[7:5]}, 32'h0);
      idle();
      check("hb_32", {29'h0, uo_out[7:5]}, 32'h1);
      for (int i = 0; i < 32; i++) idle();
      check("hb_64", {29'h0, uo_out[7:5]}, 32'h2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
